// File: rtl/counter_scheduler.sv
// Shares one up-counter among NREQ requesters via a round-robin arbiter; runs each interval to completion.
// Latency: grant one edge after req seen in IDLE; done one edge after count reaches target. No backpressure: abort ends an interval early.
module counter_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   len,
    input  logic                    abort,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic [NREQ-1:0]         done,
    output logic [WIDTH-1:0]        count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   owner_inc;
    logic [WIDTH-1:0] target;
    logic            win_vld;
    logic [PW-1:0]   win_idx;
    int              arb_idx;
    logic            at_target;

    // Round-robin search: first set req bit at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        arb_idx = 0;
        for (int k = 0; k < NREQ; k++) begin
            arb_idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_vld && req[arb_idx]) begin
                win_vld = 1'b1;
                win_idx = PW'(arb_idx);
            end
        end
    end

    assign owner_inc = (int'(owner) == NREQ - 1) ? '0 : owner + PW'(1);
    assign at_target = (count == target);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_vld) state_nxt = RUN;
            RUN:  if (abort || at_target) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
    end

    // Datapath registers; done defaults low so it is a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt    <= '0;
            done   <= '0;
            count  <= '0;
            rr_ptr <= '0;
            target <= '0;
            owner  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        owner  <= win_idx;
                        target <= len[win_idx*WIDTH +: WIDTH];
                        count  <= '0;
                        gnt    <= NREQ'(1) << win_idx;
                    end
                end
                RUN: begin
                    if (abort) begin
                        gnt    <= '0;
                        rr_ptr <= owner_inc;
                    end else if (at_target) begin
                        gnt    <= '0;
                        done   <= NREQ'(1) << owner;
                        rr_ptr <= owner_inc;
                    end else begin
                        count  <= count + WIDTH'(1);
                    end
                end
                default: gnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed bench for counter_scheduler: inputs change 1ns after each rising edge, outputs checked there too.
module tb_counter_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic                  abort;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic [NREQ-1:0]       done;
    logic [WIDTH-1:0]      count;

    int total = 0;
    int bad   = 0;

    counter_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .abort (abort),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NREQ-1:0] order [5];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        reset = 1'b1; req = '0; len = '0; abort = 1'b0;
        step(); step();
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        reset = 1'b0;

        // Single interval, len=3; req dropped during RUN is ignored.
        req = 4'b0001; len[0 +: WIDTH] = 8'd3;
        step();
        chk("t1_gnt0", gnt, 4'b0001);
        chk("t1_cnt0", count, 0);
        chk("t1_busy", busy, 1);
        req = '0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("t1_gnt", gnt, 4'b0001);
            chk("t1_cnt", count, i);
        end
        step();
        chk("t1_gnt_off", gnt, 0);
        chk("t1_done", done, 4'b0001);
        chk("t1_busy_off", busy, 0);
        chk("t1_cnt_hold", count, 3);
        step();
        chk("t1_done_off", done, 0);
        chk("t1_cnt_hold2", count, 3);

        // Round robin from pointer 0, every len=1: 2 grant cycles + 1 done cycle per requester.
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) len[i*WIDTH +: WIDTH] = 8'd1;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t2_gnt_a", gnt, order[g]);
            chk("t2_cnt_a", count, 0);
            step();
            chk("t2_gnt_b", gnt, order[g]);
            chk("t2_cnt_b", count, 1);
            if (g == 4) req = '0;
            step();
            chk("t2_gnt_idle", gnt, 0);
            chk("t2_done", done, order[g]);
        end
        step();
        chk("t2_quiet_gnt", gnt, 0);
        chk("t2_quiet_done", done, 0);

        // len=0: one grant cycle then done.
        req = 4'b0100; len[2*WIDTH +: WIDTH] = 8'd0;
        step();
        chk("t3_gnt", gnt, 4'b0100);
        chk("t3_cnt", count, 0);
        req = '0;
        step();
        chk("t3_gnt_off", gnt, 0);
        chk("t3_done", done, 4'b0100);

        // Abort at count 4; next grant must come from requester 2 upward.
        req = 4'b0010; len[1*WIDTH +: WIDTH] = 8'd10;
        step();
        chk("t4_gnt", gnt, 4'b0010);
        req = '0;
        for (int i = 0; i < 4; i++) step();
        chk("t4_cnt4", count, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_gnt_off", gnt, 0);
        chk("t4_no_done", done, 0);
        chk("t4_busy_off", busy, 0);
        chk("t4_cnt_hold", count, 4);
        req = 4'b1011;
        step();
        chk("t4_next_gnt", gnt, 4'b1000);
        abort = 1'b1; req = 4'b0001;
        step();
        chk("t4_abort2", gnt, 0);
        // abort while IDLE does not block a grant; it then aborts the new run.
        step();
        chk("t4_idle_abort", gnt, 4'b0001);
        req = '0;
        step();
        abort = 1'b0;
        chk("t4_abort3", gnt, 0);

        // Reset mid-run at count 50.
        req = 4'b0001; len[0 +: WIDTH] = 8'd200;
        step();
        chk("t5_gnt", gnt, 4'b0001);
        for (int i = 0; i < 50; i++) step();
        chk("t5_cnt50", count, 50);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t5_gnt_rst", gnt, 0);
        chk("t5_busy_rst", busy, 0);
        chk("t5_done_rst", done, 0);
        chk("t5_cnt_rst", count, 0);
        req = 4'b1001;
        step();
        chk("t5_first", gnt, 4'b0001);
        abort = 1'b1; req = '0;
        step();
        abort = 1'b0;
        chk("t5_abort", gnt, 0);

        // len=255 runs to 255 without wrapping; changing len mid-run has no effect.
        req = 4'b0001; len[0 +: WIDTH] = 8'd255;
        step();
        chk("t6_gnt", gnt, 4'b0001);
        req = '0; len[0 +: WIDTH] = 8'd5;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i == 6) begin
                chk("t6_lenchg_gnt", gnt, 4'b0001);
                chk("t6_lenchg_cnt", count, 6);
            end
        end
        chk("t6_cnt255", count, 255);
        chk("t6_gnt255", gnt, 4'b0001);
        step();
        chk("t6_done", done, 4'b0001);
        chk("t6_gnt_off", gnt, 0);
        chk("t6_cnt_hold", count, 255);
        step();
        chk("t6_done_off", done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
